// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types and constants for the register-file write-port arbiter
package wb_arb_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int RADDR_W_DEF = 3;
    localparam int REG_ZERO    = 0;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        STALL = 2'd2
    } wb_arb_state_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// rtl/wb_port_arbiter_if.sv - pipeline, MDU and register-file write-port signals of the arbiter
interface wb_port_arbiter_if #(
    parameter int DATA_W  = 16,
    parameter int RADDR_W = 3
);
    logic               pl_we;
    logic [RADDR_W-1:0] pl_addr;
    logic [DATA_W-1:0]  pl_data;
    logic               aux_valid;
    logic [RADDR_W-1:0] aux_addr;
    logic [DATA_W-1:0]  aux_data;
    logic               aux_ready;
    logic               rf_we;
    logic [RADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0]  rf_data;
    logic               stall_req;

    // Environment side: pipeline, MDU and register file.
    modport master (
        output pl_we, pl_addr, pl_data, aux_valid, aux_addr, aux_data,
        input  aux_ready, rf_we, rf_addr, rf_data, stall_req
    );

    // Arbiter side.
    modport slave (
        input  pl_we, pl_addr, pl_data, aux_valid, aux_addr, aux_data,
        output aux_ready, rf_we, rf_addr, rf_data, stall_req
    );
endinterface

// File: rtl/wb_starve_guard.sv
// rtl/wb_starve_guard.sv - counts blocked MDU cycles and requests a write-back bubble at the limit
module wb_starve_guard
    import wb_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic aux_valid,
    input  logic aux_ready,
    output logic stall_req
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STARVE_LIMIT - 1);

    wb_arb_state_t    state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            stall_req <= 1'b0;
        end else if (aux_valid && aux_ready) begin
            state     <= IDLE;
            cnt       <= '0;
            stall_req <= 1'b0;
        end else if (aux_valid) begin
            // Saturate rather than wrap so a long block can never fall back below the limit.
            if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    state     <= WAIT;
                    stall_req <= 1'b0;
                end
                WAIT: begin
                    if (cnt >= LIMIT_M1) begin
                        state     <= STALL;
                        stall_req <= 1'b1;
                    end
                end
                STALL: begin
                    stall_req <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    stall_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - shares the register-file write port between write-back and the MDU; WB_ARB_STARVE_EN adds the starvation guard
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int RADDR_W      = RADDR_W_DEF
`ifdef WB_ARB_STARVE_EN
    ,
    parameter int STARVE_LIMIT = 4
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    wb_port_arbiter_if.slave      bus
);

    localparam logic [RADDR_W-1:0] ZERO_ADDR = RADDR_W'(REG_ZERO);

    logic               pl_eff;
    logic               aux_ready_w;
    logic               rf_we_q;
    logic [RADDR_W-1:0] rf_addr_q;
    logic [DATA_W-1:0]  rf_data_q;

    assign pl_eff = bus.pl_we && (bus.pl_addr != ZERO_ADDR);

    // The MDU is consumed when the port is free, when its result is older than the
    // pipeline write to the same register, or when it targets r0.
    assign aux_ready_w = bus.aux_valid && !reset &&
                         (!pl_eff || (bus.aux_addr == bus.pl_addr) || (bus.aux_addr == ZERO_ADDR));

    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
        end else if (pl_eff) begin
            rf_we_q   <= 1'b1;
            rf_addr_q <= bus.pl_addr;
            rf_data_q <= bus.pl_data;
        end else if (bus.aux_valid && (bus.aux_addr != ZERO_ADDR)) begin
            rf_we_q   <= 1'b1;
            rf_addr_q <= bus.aux_addr;
            rf_data_q <= bus.aux_data;
        end else begin
            rf_we_q   <= 1'b0;
        end
    end

    assign bus.aux_ready = aux_ready_w;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_addr   = rf_addr_q;
    assign bus.rf_data   = rf_data_q;

`ifdef WB_ARB_STARVE_EN
    logic stall_req_w;

    wb_starve_guard #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_guard (
        .clk       (clk),
        .reset     (reset),
        .aux_valid (bus.aux_valid),
        .aux_ready (aux_ready_w),
        .stall_req (stall_req_w)
    );

    assign bus.stall_req = stall_req_w;
`else
    assign bus.stall_req = 1'b0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - directed self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic stall_exp;

    always #5 clk = ~clk;

    wb_port_arbiter_if #(.DATA_W(16), .RADDR_W(3)) bus ();

    wb_port_arbiter #(.DATA_W(16), .RADDR_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pw, input logic [2:0] pa, input logic [15:0] pd,
                         input logic av, input logic [2:0] aa, input logic [15:0] ad);
        bus.pl_we     = pw;
        bus.pl_addr   = pa;
        bus.pl_data   = pd;
        bus.aux_valid = av;
        bus.aux_addr  = aa;
        bus.aux_data  = ad;
        #1;
    endtask

    task automatic check_rf(input string tag, input logic we, input logic [2:0] a, input logic [15:0] d);
        check({tag, ".rf_we"},   32'(bus.rf_we),   32'(we));
        check({tag, ".rf_addr"}, 32'(bus.rf_addr), 32'(a));
        check({tag, ".rf_data"}, 32'(bus.rf_data), 32'(d));
    endtask

    initial begin
        drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 16'h1111);
        check("reset_aux_ready", 32'(bus.aux_ready), 32'd0);
        tick();
        tick();
        check_rf("reset", 1'b0, 3'd0, 16'h0000);
        check("reset_stall", 32'(bus.stall_req), 32'd0);
        check("reset_aux_ready2", 32'(bus.aux_ready), 32'd0);

        reset = 1'b0;
        drive(1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'h0);
        check("pl_only_ready", 32'(bus.aux_ready), 32'd0);
        tick();
        check_rf("pl_only", 1'b1, 3'd3, 16'h1234);

        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
        tick();
        check_rf("idle_hold", 1'b0, 3'd3, 16'h1234);

        drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 16'hBEEF);
        check("aux_only_ready", 32'(bus.aux_ready), 32'd1);
        tick();
        check_rf("aux_only", 1'b1, 3'd5, 16'hBEEF);

        drive(1'b1, 3'd2, 16'hAAAA, 1'b1, 3'd2, 16'h5555);
        check("waw_ready", 32'(bus.aux_ready), 32'd1);
        tick();
        check_rf("waw", 1'b1, 3'd2, 16'hAAAA);

        drive(1'b1, 3'd0, 16'hDEAD, 1'b1, 3'd4, 16'h0007);
        check("pl_r0_ready", 32'(bus.aux_ready), 32'd1);
        tick();
        check_rf("pl_r0", 1'b1, 3'd4, 16'h0007);

        drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 16'h9999);
        check("aux_r0_ready", 32'(bus.aux_ready), 32'd1);
        tick();
        check_rf("aux_r0", 1'b0, 3'd4, 16'h0007);

        drive(1'b1, 3'd7, 16'h7777, 1'b1, 3'd0, 16'h9999);
        check("aux_r0_pl_ready", 32'(bus.aux_ready), 32'd1);
        tick();
        check_rf("aux_r0_pl", 1'b1, 3'd7, 16'h7777);

        // Pipeline owns the port every cycle while the MDU waits on r6.
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, 3'd1, 16'(16'h0100 + k), 1'b1, 3'd6, 16'h0606);
            check($sformatf("starve_ready_%0d", k), 32'(bus.aux_ready), 32'd0);
            tick();
            check_rf($sformatf("starve_pl_%0d", k), 1'b1, 3'd1, 16'(16'h0100 + k));
`ifdef WB_ARB_STARVE_EN
            stall_exp = (k >= 4);
`else
            stall_exp = 1'b0;
`endif
            check($sformatf("starve_stall_%0d", k), 32'(bus.stall_req), 32'(stall_exp));
        end

        drive(1'b0, 3'd1, 16'h0, 1'b1, 3'd6, 16'h0606);
        check("drain_ready", 32'(bus.aux_ready), 32'd1);
        tick();
        check_rf("drain", 1'b1, 3'd6, 16'h0606);
        check("drain_stall", 32'(bus.stall_req), 32'd0);

        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
        tick();

        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 3'd3, 16'h3333, 1'b1, 3'd6, 16'h0A0A);
            tick();
        end
`ifdef WB_ARB_STARVE_EN
        stall_exp = 1'b1;
`else
        stall_exp = 1'b0;
`endif
        check("pre_reset_stall", 32'(bus.stall_req), 32'(stall_exp));

        reset = 1'b1;
        drive(1'b1, 3'd3, 16'h3333, 1'b1, 3'd6, 16'h0A0A);
        check("mid_reset_ready", 32'(bus.aux_ready), 32'd0);
        tick();
        check_rf("mid_reset", 1'b0, 3'd0, 16'h0000);
        check("mid_reset_stall", 32'(bus.stall_req), 32'd0);

        reset = 1'b0;
        drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd6, 16'h0A0A);
        check("post_reset_ready", 32'(bus.aux_ready), 32'd1);
        tick();
        check_rf("post_reset", 1'b1, 3'd6, 16'h0A0A);
        check("post_reset_stall", 32'(bus.stall_req), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
